// File: rtl/stat_digit_pkg.sv
// stat_digit_pkg: shared types and constants for the HUD stat digit scheduler
package stat_digit_pkg;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [2:0] {IDLE, SNAP, LOAD, SHIFT, STORE} sched_state_t;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration (add-3 then shift left)
module bcd_dabble_step #(
  parameter int NUM_DIGIT = 3,
  parameter int VAL_W     = 10
) (
  input  logic [NUM_DIGIT*4-1:0] bcd_i,
  input  logic [VAL_W-1:0]       bin_i,
  output logic [NUM_DIGIT*4-1:0] bcd_o,
  output logic [VAL_W-1:0]       bin_o
);
  logic [NUM_DIGIT*4-1:0] adj;
  always_comb begin
    adj = bcd_i;
    for (int j = 0; j < NUM_DIGIT; j++)
      adj[4*j+:4] = bcd_i[4*j+:4] >= 4'd5 ? bcd_i[4*j+:4] + 4'd3 : bcd_i[4*j+:4];
    {bcd_o, bin_o} = {adj[NUM_DIGIT*4-2:0], bin_i, 1'b0};
  end
endmodule

// File: rtl/stat_digit_scheduler.sv
// stat_digit_scheduler: time-shares one double-dabble converter across NUM_LINES stat values per frame
// Optional: STAT_DIGIT_LEADING_BLANK_EN writes leading zero digits as BLANK_DIGIT.
module stat_digit_scheduler
  import stat_digit_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int NUM_DIGIT = 3,
  parameter int VAL_W     = $clog2(10**NUM_DIGIT)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 FrameStart,
  input  logic [VAL_W-1:0]     Values [NUM_LINES],
  output logic [3:0]           Digits [NUM_LINES][NUM_DIGIT],
  output logic [NUM_LINES-1:0] DigitsValid,
  output logic                 Busy
);
  localparam int IDX_W = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam int CNT_W = VAL_W > 1 ? $clog2(VAL_W) : 1;
  localparam logic [VAL_W:0]   LIM = (VAL_W+1)'(10**NUM_DIGIT);
  localparam logic [VAL_W-1:0] SAT = VAL_W'(10**NUM_DIGIT - 1);
  sched_state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VAL_W-1:0] snap_q [NUM_LINES];
  logic [VAL_W-1:0] bin_q, bin_n, cur;
  logic [NUM_DIGIT*4-1:0] bcd_q, bcd_n;
  bcd_digit_t st [NUM_DIGIT];
  logic last;
  bcd_dabble_step #(.NUM_DIGIT(NUM_DIGIT), .VAL_W(VAL_W)) u_step (
    .bcd_i(bcd_q),
    .bin_i(bin_q),
    .bcd_o(bcd_n),
    .bin_o(bin_n)
  );
  assign Busy = state_q != IDLE;
  assign last = idx_q == IDX_W'(NUM_LINES - 1);
  assign cur  = snap_q[idx_q];
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | FrameStart;
    case (state_q)
      IDLE:    if (FrameStart || pend_q) begin
                 state_d = SNAP;
                 pend_d  = 1'b0;
               end
      SNAP:    state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = cnt_q == CNT_W'(VAL_W - 1) ? STORE : SHIFT;
      STORE:   state_d = last ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end
`ifdef STAT_DIGIT_LEADING_BLANK_EN
  logic seen;
  always_comb begin
    seen = 1'b0;
    for (int j = NUM_DIGIT - 1; j >= 0; j--) begin
      st[j] = (!seen && j != 0 && bcd_q[4*j+:4] == 4'd0) ? BLANK_DIGIT : bcd_q[4*j+:4];
      seen  = seen | (bcd_q[4*j+:4] != 4'd0);
    end
  end
`else
  always_comb begin
    for (int j = 0; j < NUM_DIGIT; j++) st[j] = bcd_q[4*j+:4];
  end
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      DigitsValid <= '0;
      for (int k = 0; k < NUM_LINES; k++) begin
        snap_q[k] <= '0;
        for (int j = 0; j < NUM_DIGIT; j++) Digits[k][j] <= '0;
      end
    end else begin
      case (state_q)
        SNAP: begin
          snap_q <= Values;
          idx_q  <= '0;
        end
        LOAD: begin
          bin_q <= {1'b0, cur} >= LIM ? SAT : cur;
          bcd_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          bin_q <= bin_n;
          bcd_q <= bcd_n;
          cnt_q <= cnt_q + 1'b1;
        end
        STORE: begin
          Digits[idx_q]      <= st;
          DigitsValid[idx_q] <= 1'b1;
          if (!last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stat_digit_scheduler.sv
// tb_stat_digit_scheduler: directed vectors with hand-computed BCD results and latency checks
module tb_stat_digit_scheduler;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       FrameStart;
  logic [9:0] Values [4];
  logic [3:0] Digits [4][3];
  logic [3:0] DigitsValid;
  logic       Busy;
  int n_vec = 0;
  int n_err = 0;
  stat_digit_scheduler dut (
    .Clk(Clk),
    .Reset(Reset),
    .FrameStart(FrameStart),
    .Values(Values),
    .Digits(Digits),
    .DigitsValid(DigitsValid),
    .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic pulse();
    FrameStart = 1'b1;
    tick(1);
    FrameStart = 1'b0;
  endtask
  task automatic setv(input int a, input int b, input int c, input int d);
    Values[0] = 10'(a);
    Values[1] = 10'(b);
    Values[2] = 10'(c);
    Values[3] = 10'(d);
  endtask
  function automatic logic [11:0] line(input int k);
    return {Digits[k][2], Digits[k][1], Digits[k][0]};
  endfunction
  // hand-written expectations use leading zeros; blanking swaps them for F
  function automatic logic [11:0] lz(input logic [11:0] x);
    logic [11:0] r;
    r = x;
`ifdef STAT_DIGIT_LEADING_BLANK_EN
    if (x[11:8] == 4'd0) r[11:8] = 4'hF;
    if (x[11:4] == 8'd0) r[7:4] = 4'hF;
`endif
    return r;
  endfunction
  task automatic chk_all(input string tag, input logic [11:0] e0, input logic [11:0] e1,
                         input logic [11:0] e2, input logic [11:0] e3);
    chk($sformatf("%s_d0", tag), 32'(line(0)), 32'(lz(e0)));
    chk($sformatf("%s_d1", tag), 32'(line(1)), 32'(lz(e1)));
    chk($sformatf("%s_d2", tag), 32'(line(2)), 32'(lz(e2)));
    chk($sformatf("%s_d3", tag), 32'(line(3)), 32'(lz(e3)));
  endtask
  initial begin
    Reset = 1'b1;
    FrameStart = 1'b0;
    setv(0, 0, 0, 0);
    tick(3);
    Reset = 1'b0;
    tick(1);
    chk("rst_digits0", 32'(line(0)), 0);
    chk("rst_digits3", 32'(line(3)), 0);
    chk("rst_valid", 32'(DigitsValid), 0);
    chk("rst_busy", 32'(Busy), 0);
    tick(20);
    chk("idle_busy", 32'(Busy), 0);
    chk("idle_valid", 32'(DigitsValid), 0);
    // basic pass; SNAP is cycle 0
    setv(0, 7, 120, 999);
    pulse();
    chk("snap_busy", 32'(Busy), 1);
    tick(12);
    chk("c12_valid", 32'(DigitsValid), 32'h0);
    tick(1);
    chk("c13_valid", 32'(DigitsValid), 32'h1);
    tick(11);
    chk("c24_d1", 32'(line(1)), 0);
    chk("c24_valid", 32'(DigitsValid), 32'h1);
    tick(1);
    chk("c25_d1", 32'(line(1)), 32'(lz(12'h007)));
    chk("c25_valid", 32'(DigitsValid), 32'h3);
    tick(23);
    chk("c48_busy", 32'(Busy), 1);
    tick(1);
    chk("c49_busy", 32'(Busy), 0);
    chk("c49_valid", 32'(DigitsValid), 32'hF);
    chk_all("p1", 12'h000, 12'h007, 12'h120, 12'h999);
    tick(10);
    chk("p1_idle_busy", 32'(Busy), 0);
    // saturation
    setv(5, 42, 1023, 1000);
    pulse();
    tick(49);
    chk_all("sat", 12'h005, 12'h042, 12'h999, 12'h999);
    // pending with value change mid-pass, plus merged extra pulses
    setv(11, 22, 33, 44);
    pulse();
    tick(10);
    setv(100, 200, 300, 400);
    pulse();
    tick(8);
    pulse();
    tick(9);
    pulse();
    tick(9);
    pulse();
    tick(9);
    chk("pend_c49_busy", 32'(Busy), 0);
    chk_all("pend_old", 12'h011, 12'h022, 12'h033, 12'h044);
    tick(1);
    chk("pend_c50_busy", 32'(Busy), 1);
    tick(48);
    chk("pend_c98_busy", 32'(Busy), 1);
    tick(1);
    chk("pend_c99_busy", 32'(Busy), 0);
    chk_all("pend_new", 12'h100, 12'h200, 12'h300, 12'h400);
    tick(20);
    chk("pend_no_third", 32'(Busy), 0);
    // FrameStart coincident with the final STORE
    setv(1, 2, 3, 4);
    pulse();
    tick(48);
    setv(9, 8, 7, 6);
    pulse();
    chk("fin_c49_busy", 32'(Busy), 0);
    chk_all("fin_old", 12'h001, 12'h002, 12'h003, 12'h004);
    tick(1);
    chk("fin_c50_busy", 32'(Busy), 1);
    tick(49);
    chk_all("fin_new", 12'h009, 12'h008, 12'h007, 12'h006);
    // blanking-style values (plain zeros when the feature is off)
    setv(0, 5, 40, 305);
    pulse();
    tick(49);
    chk_all("blank", 12'h000, 12'h005, 12'h040, 12'h305);
    // reset mid-pass
    setv(123, 456, 789, 321);
    pulse();
    tick(30);
    Reset = 1'b1;
    tick(1);
    chk("mrst_valid", 32'(DigitsValid), 0);
    chk("mrst_busy", 32'(Busy), 0);
    chk_all("mrst", 12'h000, 12'h000, 12'h000, 12'h000);
    Reset = 1'b0;
    tick(60);
    chk("mrst_quiet_busy", 32'(Busy), 0);
    chk("mrst_quiet_valid", 32'(DigitsValid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
